// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes the 16 state bytes, BPC bytes per cycle, MSB byte first.
// Uses a valid/ready handshake on both sides. A completed result is held until it is consumed.
module sub_bytes_iter #(
    parameter int unsigned BPC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
        $error("sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
    end

    localparam int              BpcI      = (BPC == 0) ? 1 : int'(BPC);
    localparam int              NumGroups = 16 / BpcI;
    localparam int              CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam logic [CntW-1:0] LastCnt   = CntW'(NumGroups - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as b^254 (0 maps to 0), followed by the forward affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;
    logic [127:0]    dout_q, dout_d;
    logic [127:0]    sub_work;
    logic [7:0]      grp_in  [BpcI];
    logic [7:0]      grp_out [BpcI];
    logic            accept;

    assign out_valid = (state_q == StDone);
    assign data_out  = dout_q;

    // Only BPC S-box copies: the current group is shifted to the top, then written back in place.
    always_comb begin
        int           base;
        logic [127:0] shifted;
        base     = int'(cnt_q) * BpcI;
        shifted  = work_q << (8 * base);
        sub_work = work_q;
        for (int k = 0; k < BpcI; k++) begin
            grp_in[k]  = shifted[127 - 8 * k -: 8];
            grp_out[k] = sbox(grp_in[k]);
        end
        for (int i = 0; i < 16; i++) begin
            if (i >= base && i < base + BpcI) begin
                sub_work[127 - 8 * i -: 8] = grp_out[i % BpcI];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dout_d   = dout_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StBusy: begin
                work_d = sub_work;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    dout_d  = sub_work;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                in_ready = out_ready;
                if (out_ready && !in_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (rst) in_ready = 1'b0;
        accept = in_valid && in_ready;
        if (accept) begin
            work_d  = data_in;
            cnt_d   = '0;
            state_d = StBusy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter. It uses a log/antilog-table S-box model.
// Stimulus is issued by a driver, and a negedge monitor checks results and handshake timing.
module tb_sub_bytes_iter;

    localparam int unsigned BPC = 4;
    localparam int          N   = 16 / BPC;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] data_in, data_out;

    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic [7:0]   exp_t[256];
    logic [7:0]   log_t[256];
    logic         rand_done;

    sub_bytes_iter #(.BPC(BPC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic init_tables();
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = 8'(i);
            x = x ^ xt(x);  // multiply by generator 3
        end
    endtask

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [7:0] v, s, c;
        c = 8'h63;
        v = (b == 8'h00) ? 8'h00 : exp_t[(255 - int'(log_t[b])) % 255];
        for (int i = 0; i < 8; i++)
            s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = sbox_ref(d[127 - 8 * i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e);
        int t;
        t = 0;
        in_valid = 1'b1;
        data_in  = d;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) fail("accept_timeout");
        else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        data_in  = rnd128();
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
    endtask

    // Monitor
    logic prev_ov = 1'b0, prev_or = 1'b0, prev_rst = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (prev_ov && !prev_or && !prev_rst) check("hold_valid", 128'(out_valid), 128'd1);
            if (out_valid) check("in_ready_in_done", 128'(in_ready), 128'(out_ready));
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) fail("spurious_valid");
                else check("latency", 128'(cyc - acc_q.pop_front()), 128'(N + 1));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) fail("unexpected_output");
                else begin
                    check("data_out", data_out, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_ov  = out_valid;
        prev_or  = out_ready;
        prev_rst = rst;
    end

    initial begin
        logic [127:0] d;
        int           t;
        init_tables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        rand_done = 1'b0;

        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_data_out", data_out, 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        // FIPS-197 App.B vector and corner bytes
        send(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230);
        idle();
        drain();
        send({16{8'h00}}, {16{8'h63}});
        send({16{8'hff}}, {16{8'h16}});
        send({16{8'h53}}, {16{8'hed}});
        idle();
        drain();

        // Backpressure: result must hold while new input is offered
        out_ready = 1'b0;
        d = rnd128();
        send(d, model(d));
        idle();
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        if (!out_valid) fail("bp_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            data_in  = rnd128();
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_valid", 128'(out_valid), 128'd0);
        check("bp_idle_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held
        for (int i = 0; i < 3; i++) begin
            d = rnd128();
            send(d, model(d));
        end
        idle();
        drain();

        // Reset in the middle of BUSY (cnt = 2)
        d = rnd128();
        send(d, model(d));
        idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_in_reset", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_data_out", data_out, 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        d = rnd128();
        send(d, model(d));
        idle();
        drain();

        // All byte values through positions 0 and 15
        for (int v = 0; v < 256; v++) begin
            d = rnd128();
            d[127:120] = 8'(v);
            d[7:0]     = 8'(v);
            send(d, model(d));
        end
        idle();
        drain();

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    d = rnd128();
                    send(d, model(d));
                    if ($urandom_range(0, 2) == 0) begin
                        idle();
                        repeat ($urandom_range(1, 4)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
